// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an N-bit universal shift register unit: accepts one
// command at a time and paces load/shift steps, then reports the resulting value.
module shift_sequencer #(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 4,
    parameter int unsigned CW  = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    input  logic [N-1:0]  cmd_data,
    input  logic          ser_in,
    input  logic [N-1:0]  fu_q,
    output logic [2:0]    fu_s,
    output logic          fu_enable,
    output logic [N-1:0]  fu_d,
    output logic          fu_msb_in,
    output logic          fu_lsb_in,
    output logic          ser_out,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  data_q, data_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] remain_q, remain_d;
    logic [2:0]    fu_s_d;
    logic          fu_enable_d;
    logic [N-1:0]  fu_d_d;

    // State, command latches and registered unit controls (computed from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            data_q    <= '0;
            presc_q   <= '0;
            remain_q  <= '0;
            fu_s      <= 3'd0;
            fu_enable <= 1'b0;
            fu_d      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            presc_q   <= presc_d;
            remain_q  <= remain_d;
            fu_s      <= fu_s_d;
            fu_enable <= fu_enable_d;
            fu_d      <= fu_d_d;
            done      <= (state_d == DONE);
            busy      <= (state_d != IDLE);
            if (state_q == DONE) begin
                result <= fu_q;
            end
        end
    end

    // Next-state logic; a step fires on the last prescaler count
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        presc_d  = presc_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    data_d   = cmd_data;
                    presc_d  = '0;
                    remain_d = cmd_count;
                    if (cmd_op == 3'd1) begin
                        state_d = LOAD;
                    end else if (cmd_op == 3'd0 || cmd_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            LOAD: state_d = DONE;
            SHIFT: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fu_s_d      = (state_d == LOAD || state_d == SHIFT) ? op_d : 3'd0;
        fu_enable_d = (state_d == LOAD) || (state_d == SHIFT && presc_d == PRESC_LAST);
        fu_d_d      = (state_d == LOAD) ? data_d : '0;
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign fu_msb_in = (op_q == 3'd2) && ser_in;
    assign fu_lsb_in = (op_q == 3'd3) && ser_in;

    // Bit that leaves the register on the next step of the latched op
    always_comb begin
        ser_out = 1'b0;
        case (op_q)
            3'd2, 3'd4, 3'd6: ser_out = fu_q[0];
            3'd3, 3'd5, 3'd7: ser_out = fu_q[N-1];
            default:          ser_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed scenarios plus random commands,
// with a behavioural shift-register unit attached to the sequencer.
module tb_shift_sequencer;

    localparam int unsigned N   = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned CW  = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [N-1:0]  cmd_data;
    logic          ser_in;
    logic [N-1:0]  fu_q;
    logic [2:0]    fu_s;
    logic          fu_enable;
    logic [N-1:0]  fu_d;
    logic          fu_msb_in;
    logic          fu_lsb_in;
    logic          ser_out;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    shift_sequencer #(.N(N), .DIV(DIV), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .ser_in(ser_in),
        .fu_q(fu_q), .fu_s(fu_s), .fu_enable(fu_enable), .fu_d(fu_d),
        .fu_msb_in(fu_msb_in), .fu_lsb_in(fu_lsb_in), .ser_out(ser_out),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] data;
        logic [N-1:0] res;
        int unsigned  cyc;
        int unsigned  en;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [N-1:0] fq = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural universal shift register driven by the sequencer
    always @(posedge clk) begin
        if (fu_enable) begin
            case (fu_s)
                3'd1: fq <= fu_d;
                3'd2: fq <= {fu_msb_in, fq[N-1:1]};
                3'd3: fq <= {fq[N-2:0], fu_lsb_in};
                3'd4: fq <= {fq[0], fq[N-1:1]};
                3'd5: fq <= {fq[N-2:0], fq[N-1]};
                3'd6: fq <= {fq[N-1], fq[N-1:1]};
                3'd7: fq <= {fq[N-2:0], 1'b0};
                default: fq <= fq;
            endcase
        end
    end
    assign fu_q = fq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference result of a command applied to a starting register value
    function automatic logic [N-1:0] model(input logic [2:0] op, input int cnt,
                                           input logic [N-1:0] d, input logic s,
                                           input logic [N-1:0] q);
        logic [N-1:0] r;
        logic [N-1:0] msb;
        r   = q;
        msb = N'(1) << (N - 1);
        if (op == 3'd0) return q;
        if (op == 3'd1) return d;
        for (int k = 0; k < cnt; k++) begin
            case (op)
                3'd2: r = (r >> 1) | (s ? msb : N'(0));
                3'd3: r = (r << 1) | N'(s);
                3'd4: r = (r >> 1) | ((r % 2 == 1) ? msb : N'(0));
                3'd5: r = (r << 1) | (((r & msb) != 0) ? N'(1) : N'(0));
                3'd6: r = (r >> 1) | (r & msb);
                default: r = r << 1;
            endcase
        end
        return r;
    endfunction

    // Wait for acceptance of the currently driven command and queue its expectation
    task automatic wait_accept(output int unsigned acc);
        exp_t e;
        acc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready && cmd_valid) begin
                e.op   = cmd_op;
                e.data = cmd_data;
                e.res  = model(cmd_op, int'(cmd_count), cmd_data, ser_in, fq);
                if (cmd_op == 3'd1) begin
                    e.cyc = cyc + 2;
                    e.en  = 1;
                end else if (cmd_op == 3'd0 || cmd_count == '0) begin
                    e.cyc = cyc + 1;
                    e.en  = 0;
                end else begin
                    e.cyc = cyc + int'(cmd_count) * DIV + 1;
                    e.en  = int'(cmd_count);
                end
                sb.push_back(e);
                acc = cyc;
                return;
            end
        end
        fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt,
                         input logic [N-1:0] d, input logic s, input int gap);
        int unsigned acc;
        wait_idle();
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = d;
        ser_in    = s;
        wait_accept(acc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Monitor: checks unit pulses against the front expectation and pops on done
    int unsigned  en_cnt = 0;
    bit           res_pend = 1'b0;
    logic [N-1:0] res_exp = '0;
    always @(negedge clk) begin
        exp_t e;
        logic exp_so;
        if (rst) begin
            en_cnt   = 0;
            res_pend = 1'b0;
        end else begin
            if (res_pend) begin
                check("result", 32'(result), 32'(res_exp));
                res_pend = 1'b0;
            end
            if (fu_enable) begin
                en_cnt++;
                if (sb.size() == 0) begin
                    fail_now("enable_without_command");
                end else begin
                    check("fu_s", 32'(fu_s), 32'(sb[0].op));
                    if (sb[0].op == 3'd1) check("fu_d", 32'(fu_d), 32'(sb[0].data));
                    case (sb[0].op)
                        3'd2, 3'd4, 3'd6: exp_so = fq[0];
                        3'd3, 3'd5, 3'd7: exp_so = fq[N-1];
                        default:          exp_so = 1'b0;
                    endcase
                    check("ser_out", 32'(ser_out), 32'(exp_so));
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("enable_pulses", en_cnt, e.en);
                    res_exp  = e.res;
                    res_pend = 1'b1;
                end
                en_cnt = 0;
            end
        end
    end

    initial begin
        int unsigned a1, a2;
        int          n, ndone;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_count = '0;
        cmd_data  = '0;
        ser_in    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fu_enable", 32'(fu_enable), 32'd0);
        check("rst_fu_s", 32'(fu_s), 32'd0);
        check("rst_fu_d", 32'(fu_d), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Directed scenarios
        issue(3'd1, CW'(0), 8'hA5, 1'b0, 0);
        issue(3'd1, CW'(0), 8'h00, 1'b0, 0);
        issue(3'd2, CW'(8), 8'h00, 1'b1, 0);
        issue(3'd1, CW'(0), 8'h81, 1'b0, 1);
        issue(3'd5, CW'(3), 8'h00, 1'b0, 0);
        issue(3'd6, CW'(0), 8'h00, 1'b0, 0);

        // Valid held high: second command only in the cycle after done
        issue(3'd1, CW'(0), 8'h80, 1'b0, 0);
        wait_idle();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_count = CW'(2);
        ser_in    = 1'b0;
        wait_accept(a1);
        wait_accept(a2);
        check("back_to_back_gap", a2 - a1, 2 * DIV + 2);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        // Reset in the middle of a shift
        wait_idle();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_count = CW'(8);
        wait_accept(a1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(negedge clk);
            if (fu_enable) n++;
        end
        check("steps_before_abort", n, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_fu_enable", 32'(fu_enable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(7, 0)), CW'($urandom_range((1 << CW) - 1, 0)),
                  N'($urandom), 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
